// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter in front of the single-port data memory
//
// Purpose:
//   Shares one synchronous single-port dmem between the processor load/store
//   path (priority requester) and the loader/debug port. At most one access
//   is issued per cycle. Read data comes back one cycle after the grant and is
//   tagged to the requester that issued it. The loader is forced through after
//   MAX_WAIT consecutive lost cycles, so it cannot be starved.
//
// Parameters:
//   ADDR_W    dmem word-address width
//   DATA_W    data width
//   MAX_WAIT  consecutive lost loader cycles before the loader wins (1..15)
//
// Ports:
//   clock, reset                      clock and asynchronous active-high reset
//   p_req/p_wren/p_addr/p_data        processor request
//   p_gnt                             processor access issued this cycle (comb)
//   p_rvalid/p_q                      processor read return (rvalid registered)
//   l_req/l_wren/l_addr/l_data        loader request
//   l_gnt                             loader access issued this cycle (comb)
//   l_rvalid/l_q                      loader read return (rvalid registered)
//   address_dmem/data/wren            to dmem
//   q_dmem                            from dmem, valid the cycle after the address edge

module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_q,

    input  logic              l_req,
    input  logic              l_wren,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_data,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_q,

    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic [1:0] r_rd_owner;   // [0] = processor read in flight, [1] = loader read in flight

    logic w_force_l;
    logic w_p_gnt;
    logic w_l_gnt;

    // Loader has waited long enough: it overrides processor priority for one cycle.
    assign w_force_l = l_req & (r_wait_cnt == MAX_WAIT_C);
    assign w_p_gnt   = p_req & ~w_force_l;
    assign w_l_gnt   = l_req & (~p_req | w_force_l);

    assign p_gnt = w_p_gnt;
    assign l_gnt = w_l_gnt;

    // Processor drives the bus when idle so the address mux needs only one select.
    assign address_dmem = w_l_gnt ? l_addr : p_addr;
    assign data         = w_l_gnt ? l_data : p_data;

    // Gated by reset so no write can land in memory while the system is held in reset.
    assign wren = ~reset & ((w_p_gnt & p_wren) | (w_l_gnt & l_wren));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
            r_rd_owner <= 2'b00;
        end else begin
            if (l_req & ~w_l_gnt) begin
                // Saturate defensively; force_l normally grants before the limit is passed.
                if (r_wait_cnt != MAX_WAIT_C) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_wait_cnt <= 4'd0;
            end
            r_rd_owner <= {w_l_gnt & ~l_wren, w_p_gnt & ~p_wren};
        end
    end

    assign p_rvalid = r_rd_owner[0];
    assign l_rvalid = r_rd_owner[1];
    assign p_q      = q_dmem;
    assign l_q      = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          p_req = 1'b0, p_wren = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          l_req = 1'b0, l_wren = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_data = '0;
    logic          p_gnt, p_rvalid, l_gnt, l_rvalid, wren;
    logic [DW-1:0] p_q, l_q, data, q_dmem;
    logic [AW-1:0] address_dmem;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_q(p_q),
        .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_data(l_data),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_q(l_q),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    always #5 clock = ~clock;

    // Write-first synchronous single-port memory standing in for dmem.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (wren) mem[address_dmem] <= data;
        q_dmem <= wren ? data : mem[address_dmem];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the memory should hold, how long the loader has lost,
    // and which read (if any) is owed to each requester next cycle.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_lost = 0;
    bit            m_pend_p = 0, m_pend_l = 0;
    logic [DW-1:0] m_q_p = '0, m_q_l = '0;
    bit            g_p, g_l;

    task automatic step(input bit rst,
                        input bit pr, input bit pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input bit lr, input bit lw, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        bit frc, ep, el, ew;
        @(posedge clock);
        #1;
        reset = rst;
        p_req = pr; p_wren = pw; p_addr = pa; p_data = pd;
        l_req = lr; l_wren = lw; l_addr = la; l_data = ld;
        @(negedge clock);
        check_eq("p_rvalid", p_rvalid, rst ? 1'b0 : m_pend_p);
        check_eq("l_rvalid", l_rvalid, rst ? 1'b0 : m_pend_l);
        if (!rst && m_pend_p) check_eq("p_q", p_q, m_q_p);
        if (!rst && m_pend_l) check_eq("l_q", l_q, m_q_l);
        frc = lr && (m_lost >= MW);
        ep  = pr && !frc;
        el  = lr && (!pr || frc);
        ew  = !rst && ((ep && pw) || (el && lw));
        check_eq("p_gnt", p_gnt, ep);
        check_eq("l_gnt", l_gnt, el);
        check_eq("wren", wren, ew);
        check_eq("address_dmem", address_dmem, el ? la : pa);
        check_eq("data", data, el ? ld : pd);
        m_pend_p = !rst && ep && !pw;
        m_pend_l = !rst && el && !lw;
        if (m_pend_p) m_q_p = ref_mem[pa];
        if (m_pend_l) m_q_l = ref_mem[la];
        if (ew) ref_mem[el ? la : pa] = el ? ld : pd;
        m_lost = (rst || !lr || el) ? 0 : m_lost + 1;
        g_p = ep;
        g_l = el;
    endtask

    task automatic idle(input bit rst);
        step(rst, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    bit            rp, rpw, rl, rlw;
    logic [AW-1:0] rpa, rla;
    logic [DW-1:0] rpd, rld;

    initial begin
        // Reset with both requesting and a processor write pending: wren must stay low.
        step(1, 1, 1, 12'h005, 32'h1111_1111, 1, 0, 12'h006, '0);
        step(1, 1, 1, 12'h005, 32'h1111_1111, 1, 1, 12'h006, 32'h2);
        idle(0);

        // Fill the low addresses and the directed locations through the loader.
        for (int a = 0; a < 16; a++) step(0, 0, 0, '0, '0, 1, 1, 12'(a), $urandom);
        step(0, 1, 1, 12'h010, 32'hDEAD_BEEF, 0, 0, '0, '0);
        step(0, 1, 1, 12'h001, 32'h0000_000A, 0, 0, '0, '0);
        step(0, 1, 1, 12'h002, 32'h0000_000B, 0, 0, '0, '0);

        // Processor read alone.
        step(0, 1, 0, 12'h010, '0, 0, 0, '0, '0);
        check_eq("prd_gnt", p_gnt, 1'b1);
        idle(0);
        check_eq("prd_rvalid", p_rvalid, 1'b1);
        check_eq("prd_q", p_q, 32'hDEAD_BEEF);
        check_eq("prd_l_rvalid", l_rvalid, 1'b0);

        // Loader write, then an immediate processor read of the same word.
        step(0, 0, 0, '0, '0, 1, 1, 12'h0FF, 32'h1234_5678);
        check_eq("lwr_wren", wren, 1'b1);
        step(0, 1, 0, 12'h0FF, '0, 0, 0, '0, '0);
        check_eq("lwr_l_rvalid", l_rvalid, 1'b0);
        idle(0);
        check_eq("raw_q", p_q, 32'h1234_5678);

        // Continuous contention: P wins MW cycles, L wins the next one, repeating.
        for (int c = 0; c < 3 * (MW + 1); c++) begin
            step(0, 1, 0, 12'(c % 16), '0, 1, 0, 12'(15 - (c / (MW + 1))), '0);
            check_eq("starve_p_gnt", p_gnt, (c % (MW + 1)) != MW);
            check_eq("starve_l_gnt", l_gnt, (c % (MW + 1)) == MW);
        end
        idle(0);

        // Alternating owners, back-to-back reads.
        step(0, 1, 0, 12'h001, '0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, 1, 0, 12'h002, '0);
        check_eq("alt_p_q", p_q, 32'hA);
        step(0, 1, 0, 12'h001, '0, 0, 0, '0, '0);
        check_eq("alt_l_rvalid", l_rvalid, 1'b1);
        check_eq("alt_l_q", l_q, 32'hB);
        idle(0);
        check_eq("alt_p_q2", p_q, 32'hA);

        // Reset lands the cycle after a read grant: the read is discarded.
        step(0, 1, 0, 12'h010, '0, 0, 0, '0, '0);
        idle(1);
        check_eq("rstmid_p_rvalid", p_rvalid, 1'b0);
        idle(1);
        idle(0);
        check_eq("rstmid_after", p_rvalid, 1'b0);

        // Randomized traffic with held requests, occasional cancels and resets.
        rp = 0; rl = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            if (!rp && $urandom_range(0, 9) < 6) begin
                rp = 1; rpw = $urandom_range(0, 2) == 0; rpa = 12'($urandom_range(0, 15)); rpd = $urandom;
            end else if (rp && $urandom_range(0, 19) == 0) begin
                rp = 0;
            end
            if (!rl && $urandom_range(0, 9) < 6) begin
                rl = 1; rlw = $urandom_range(0, 1) == 0; rla = 12'($urandom_range(0, 15)); rld = $urandom;
            end else if (rl && $urandom_range(0, 29) == 0) begin
                rl = 0;
            end
            rst = $urandom_range(0, 99) == 0;
            step(rst, rp, rpw, rpa, rpd, rl, rlw, rla, rld);
            if (g_p) rp = 0;
            if (g_l) rl = 0;
        end
        idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data memory (`dmem`) between two requesters: the processor's load/store path and a loader/debug port that fills or inspects memory. Each cycle it issues at most one access, returns read data one cycle later to the requester that issued it, and stops the loader from being starved. It sits between `processor`/loader and `dmem` inside `skeleton`, with all ports on the same clock as `dmem`.

## Interface
- `ADDR_W`, 12: dmem word-address width.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: consecutive lost cycles after which the loader wins (legal range 1..15).

- `clock`  in  1: single clock. Rising edge; dmem is clocked on the same edge.
- `reset`  in  1: asynchronous, active-high.
- `p_req`  in  1: processor access request.
- `p_wren`  in  1: 1 = write, 0 = read.
- `p_addr`  in  ADDR_W: processor address.
- `p_data`  in  DATA_W: processor write data.
- `p_gnt`  out  1: processor access issued this cycle (combinational).
- `p_rvalid`  out  1: `p_q` valid (registered).
- `p_q`  out  DATA_W: read data returned to the processor.
- `l_req`, `l_wren`, `l_addr`, `l_data`, `l_gnt`, `l_rvalid`, `l_q`: loader equivalents of the processor signals.
- `address_dmem`  out  ADDR_W: to dmem.
- `data`  out  DATA_W: to dmem.
- `wren`  out  1: to dmem.
- `q_dmem`  in  DATA_W: from dmem. Valid in the cycle after the address edge.

## Operation
- **Arbitration (combinational):**
  - The processor has priority: `p_gnt = p_req & ~force_l`.
  - `l_gnt = l_req & (~p_req | force_l)`.
  - `force_l = l_req & (wait_cnt == MAX_WAIT)`.
  - `p_gnt` and `l_gnt` are never both high.
- **Memory mux:**
  - `address_dmem`/`data` come from the granted requester. They come from the processor when neither is granted.
  - `wren = (p_gnt & p_wren) | (l_gnt & l_wren)`. `wren` is 0 when no grant is active, and 0 while `reset` is high.
- **Starvation counter:** `wait_cnt`, 4 bits, registered.
  - Increments on `l_req & ~l_gnt`.
  - Clears on `l_gnt` or `~l_req`.
  - Never exceeds `MAX_WAIT`.
- **Read return pipeline:** registered `rd_owner[1:0]`.
  - Bit 0 is set on an edge where `p_gnt & ~p_wren`; bit 1 is set on an edge where `l_gnt & ~l_wren`.
  - `p_rvalid = rd_owner[0]` and `l_rvalid = rd_owner[1]`.
  - `p_q` and `l_q` are both driven from `q_dmem`. Each is meaningful only while its `rvalid` is high.
- **Writes:** no response. The write completes at the issuing edge.
- **Requester rules:**
  - Hold `req`, `wren`, `addr` and `data` stable until the cycle `gnt` is high.
  - The request is consumed on that edge.
  - Dropping `req` before grant cancels the request with no side effects.
- **Reset:** asynchronous. Clears `wait_cnt` and `rd_owner`. An in-flight read is discarded with no `rvalid`.

## Timing
- **Reset values:** `p_rvalid = l_rvalid = 0`. `wait_cnt = 0`. `wren = 0`. `p_gnt`/`l_gnt` follow `req` once reset deasserts.
- **Grant latency:** 0 cycles, same cycle as `req` when uncontended.
- **Read latency:** data is returned exactly 1 cycle after the grant cycle; `rvalid` is high for 1 cycle.
- **Throughput:** one access per cycle. Back-to-back reads from alternating owners produce back-to-back `rvalid`s with correct owner tags.
- **Read-after-write to the same address in consecutive cycles:** the read returns the newly written value (dmem write-first behaviour is required of the dmem instance).
- **Continuous contention:** the processor wins `MAX_WAIT` cycles, then the loader wins 1 cycle; the period is `MAX_WAIT+1`.
- **Reset asserted in the cycle after a read grant:** `rvalid` is forced low immediately and stays 0.

## Test plan
- **Reset:** assert `reset` with `p_req = l_req = 1`, `p_wren = 1` -> `wren = 0`, `p_rvalid = l_rvalid = 0`, `wait_cnt = 0`.
- **Processor read alone:** mem[0x010] = 0xDEADBEEF; `p_req` read 0x010 -> `p_gnt = 1` that cycle; next cycle `p_rvalid = 1`, `p_q = 0xDEADBEEF`, `l_rvalid = 0`.
- **Write then read:** loader writes 0x12345678 to 0x0FF -> `l_gnt = 1`, `wren = 1` for one cycle, `l_rvalid` never high. A following processor read of 0x0FF returns 0x12345678.
- **Starvation:** `MAX_WAIT = 4`, both requesting reads continuously -> `p_gnt` in cycles 0-3, `l_gnt` in cycle 4, `wait_cnt` back to 0, pattern repeats every 5 cycles, and each `rvalid` is tagged to the correct owner.
- **Alternating reads:** mem[1] = 0xA, mem[2] = 0xB; grants alternate P(1), L(2), P(1) -> `p_rvalid`/`p_q = 0xA`, then `l_rvalid`/`l_q = 0xB`, then `p_rvalid`/`p_q = 0xA`, each one cycle after its grant.
- **Reset mid-read:** processor read granted, then `reset` asserted in the next cycle -> `p_rvalid` stays 0, and no spurious `rvalid` follows after reset is released.
